// File: rtl/stim_pkg.sv
// Shared types and default widths for the timed-stimulus player.
package stim_pkg;

   localparam int unsigned VEC_W      = 9;
   localparam int unsigned TIME_W     = 16;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned ENTRY_W    = TIME_W + VEC_W + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [TIME_W-1:0] tstamp;
      logic [VEC_W-1:0]  vec;
      logic              last;
   } entry_t;

endpackage

// File: rtl/stim_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered ready/empty flags.
import stim_pkg::*;

module stim_fifo #(
   parameter int unsigned W     = ENTRY_W,
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         ready,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [AW:0]  wr_nxt_c;
   logic [AW:0]  rd_nxt_c;
   logic         push_ok_c;
   logic         pop_ok_c;

   // A full FIFO refuses pushes even when a pop is happening the same cycle.
   assign push_ok_c = push && ready;
   assign pop_ok_c  = pop && !empty;
   assign wr_nxt_c  = wr_ptr + {{AW{1'b0}}, push_ok_c};
   assign rd_nxt_c  = rd_ptr + {{AW{1'b0}}, pop_ok_c};
   assign head      = mem[rd_ptr[AW-1:0]];

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   // Pointers and flags, with flags computed from the next pointer values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b1;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_nxt_c;
         rd_ptr <= rd_nxt_c;
         empty  <= (wr_nxt_c == rd_nxt_c);
         ready  <= !((wr_nxt_c[AW] != rd_nxt_c[AW]) &&
                     (wr_nxt_c[AW-1:0] == rd_nxt_c[AW-1:0]));
      end
   end

endmodule

// File: rtl/stim_player.sv
// Timed-stimulus sequencer: applies queued vectors when the run counter reaches their timestamp.
import stim_pkg::*;

module stim_player #(
   parameter int unsigned DEPTH = FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [TIME_W-1:0] load_time,
   input  logic [VEC_W-1:0]  load_vec,
   input  logic              load_last,
   input  logic              start,
   output logic              busy,
   output logic [VEC_W-1:0]  vec_out,
   output logic              vec_strobe,
   output logic              late_err,
   output logic              done
);

   state_t             state;
   logic [TIME_W-1:0]  tcount;
   entry_t             load_entry;
   entry_t             head;
   logic [ENTRY_W-1:0] head_bits;
   logic               fifo_empty;
   logic               pop_c;

   assign load_entry = '{tstamp: load_time, vec: load_vec, last: load_last};
   assign head       = entry_t'(head_bits);

   // Pop the head once its timestamp has been reached (or already passed).
   assign pop_c = (state == S_RUN) && !fifo_empty && (head.tstamp <= tcount);

   stim_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (load_valid),
      .din   (ENTRY_W'(load_entry)),
      .pop   (pop_c),
      .head  (head_bits),
      .ready (load_ready),
      .empty (fifo_empty)
   );

   // Run-control FSM, saturating cycle counter and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tcount     <= '0;
         vec_out    <= '0;
         vec_strobe <= 1'b0;
         late_err   <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         vec_strobe <= 1'b0;
         late_err   <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state  <= S_RUN;
                  tcount <= '0;
                  done   <= 1'b0;
                  busy   <= 1'b1;
               end
            end
            S_RUN: begin
               if (tcount != {TIME_W{1'b1}}) begin
                  tcount <= tcount + TIME_W'(1);
               end
               if (pop_c) begin
                  vec_out    <= head.vec;
                  vec_strobe <= 1'b1;
                  late_err   <= (head.tstamp < tcount);
                  if (head.last) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stim_player.sv
// Directed self-checking bench for stim_player.
`timescale 1ns/1ps
module tb_stim_player;
   import stim_pkg::*;

   logic              clk;
   logic              rst_n;
   logic              load_valid;
   logic              load_ready;
   logic [TIME_W-1:0] load_time;
   logic [VEC_W-1:0]  load_vec;
   logic              load_last;
   logic              start;
   logic              busy;
   logic [VEC_W-1:0]  vec_out;
   logic              vec_strobe;
   logic              late_err;
   logic              done;

   int tests = 0;
   int fails = 0;
   int strobes;
   int lates;

   stim_player dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_time  (load_time),
      .load_vec   (load_vec),
      .load_last  (load_last),
      .start      (start),
      .busy       (busy),
      .vec_out    (vec_out),
      .vec_strobe (vec_strobe),
      .late_err   (late_err),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int t, input int v, input bit last);
      load_valid = 1'b1;
      load_time  = TIME_W'(t);
      load_vec   = VEC_W'(v);
      load_last  = last;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_ticks(input int n, output int s, output int l);
      s = 0;
      l = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (vec_strobe) s++;
         if (late_err) l++;
      end
   endtask

   initial begin
      rst_n = 1'b0; load_valid = 1'b0; load_time = '0; load_vec = '0;
      load_last = 1'b0; start = 1'b0;
      tick(); tick();
      check("rst_vec", 32'(vec_out), 0);
      check("rst_strobe", 32'(vec_strobe), 0);
      check("rst_busy_done", 32'({busy, done, late_err}), 0);
      check("rst_ready", 32'(load_ready), 1);
      rst_n = 1'b1;
      tick();

      // Basic timing
      push(3, 9'h035, 1'b0);
      push(6, 9'h1F1, 1'b1);
      pulse_start();                         // E0
      check("basic_busy", 32'({busy, done}), 32'b10);
      run_ticks(3, strobes, lates);          // E0+1..E0+3
      check("basic_pre_strobes", 32'(strobes), 0);
      check("basic_pre_vec", 32'(vec_out), 0);
      tick();                                // E0+4
      check("basic_v1", 32'(vec_out), 32'h035);
      check("basic_s1", 32'({vec_strobe, late_err}), 32'b10);
      run_ticks(2, strobes, lates);          // E0+5..E0+6
      check("basic_mid_strobes", 32'(strobes), 0);
      check("basic_mid_done", 32'(done), 0);
      tick();                                // E0+7
      check("basic_v2", 32'(vec_out), 32'h1F1);
      check("basic_s2", 32'({vec_strobe, late_err}), 32'b10);
      check("basic_done", 32'({busy, done}), 32'b01);
      tick();
      check("basic_hold", 32'({vec_out, vec_strobe, done}), 32'({9'h1F1, 1'b0, 1'b1}));

      // Late entry
      push(5, 9'h0AA, 1'b0);
      push(2, 9'h155, 1'b1);
      pulse_start();
      run_ticks(5, strobes, lates);          // E0+1..E0+5
      check("late_pre_strobes", 32'(strobes), 0);
      tick();                                // E0+6
      check("late_v1", 32'({vec_out, vec_strobe, late_err}), 32'({9'h0AA, 2'b10}));
      tick();                                // E0+7
      check("late_v2", 32'({vec_out, vec_strobe, late_err}), 32'({9'h155, 2'b11}));
      check("late_done", 32'(done), 1);
      tick();
      check("late_clear", 32'({vec_strobe, late_err}), 0);

      // Full FIFO
      for (int i = 0; i < 8; i++) begin
         push(i + 1, 32'h100 + i, i == 7);
         if (i == 6) check("full_ready7", 32'(load_ready), 1);
      end
      check("full_ready8", 32'(load_ready), 0);
      push(1, 9'h1FF, 1'b0);                 // refused
      check("full_ready9", 32'(load_ready), 0);
      pulse_start();                         // E0
      tick();                                // E0+1
      check("full_ready_e1", 32'(load_ready), 0);
      tick();                                // E0+2, first pop
      check("full_pop1", 32'({vec_out, vec_strobe}), 32'({9'h100, 1'b1}));
      check("full_ready_back", 32'(load_ready), 1);
      run_ticks(7, strobes, lates);          // E0+3..E0+9
      check("full_strobes", 32'(strobes), 7);
      check("full_lates", 32'(lates), 0);
      check("full_last", 32'({vec_out, done}), 32'({9'h107, 1'b1}));

      // Empty wait
      pulse_start();                         // E0
      run_ticks(4, strobes, lates);          // E0+1..E0+4
      check("empty_idle_strobes", 32'(strobes), 0);
      check("empty_busy", 32'(busy), 1);
      push(10, 9'h0C3, 1'b1);                // E0+5, tcount was 4
      run_ticks(5, strobes, lates);          // E0+6..E0+10
      check("empty_early", 32'(strobes), 0);
      tick();                                // E0+11
      check("empty_apply", 32'({vec_out, vec_strobe, late_err}), 32'({9'h0C3, 2'b10}));
      check("empty_done", 32'(done), 1);

      // Mid-run reset
      push(20, 9'h001, 1'b0);
      push(21, 9'h002, 1'b0);
      push(22, 9'h003, 1'b1);
      pulse_start();
      tick(); tick();
      check("mrst_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_outs", 32'({vec_out, vec_strobe, late_err, done, busy}), 0);
      check("mrst_ready", 32'(load_ready), 1);
      pulse_start();
      check("mrst_run", 32'(busy), 1);
      run_ticks(30, strobes, lates);
      check("mrst_no_strobes", 32'(strobes), 0);
      check("mrst_vec", 32'(vec_out), 0);

      // Restart from DONE
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      push(2, 9'h011, 1'b1);
      push(3, 9'h022, 1'b0);
      push(5, 9'h033, 1'b1);
      pulse_start();                         // E0
      run_ticks(3, strobes, lates);          // E0+1..E0+3
      check("rs_first", 32'({vec_out, done, busy}), 32'({9'h011, 2'b10}));
      run_ticks(4, strobes, lates);
      check("rs_held", 32'(strobes), 0);
      pulse_start();                         // E0'
      check("rs_done_drop", 32'({done, busy}), 32'b01);
      run_ticks(3, strobes, lates);          // E0'+1..E0'+3
      check("rs_wait", 32'(strobes), 0);
      tick();                                // E0'+4
      check("rs_v2", 32'({vec_out, vec_strobe, late_err}), 32'({9'h022, 2'b10}));
      tick(); tick();                        // E0'+6
      check("rs_v3", 32'({vec_out, vec_strobe, late_err}), 32'({9'h033, 2'b10}));
      check("rs_done", 32'({done, busy}), 32'b10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
